// File: rtl/dmem_port_arbiter_if.sv
// One requester port into the data-memory arbiter: request fields in, comb grant plus
// registered 1-cycle response out. master = requester side, slave = arbiter side.
interface dmem_port_arbiter_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  func3;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, addr, wdata, func3,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata, func3,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin, burst-capped sharing of the single-port data memory between CPU and I2C buffer.
// Grant is comb in the request cycle, response 1 cycle later; a losing requester just holds req.
module dmem_port_arbiter #(
    parameter int MEM_BYTES = 1024,
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    dmem_port_arbiter_if.slave  cpu,
    dmem_port_arbiter_if.slave  i2c,
    output logic                mem_we,
    output logic [31:0]         mem_a,
    output logic [31:0]         mem_wd,
    output logic [2:0]          mem_func3,
    input  logic [31:0]         mem_rd
);

    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_I2C = 1'b1
    } owner_e;

    owner_e         last_owner;
    owner_e         winner;
    owner_e         other_owner;
    logic [CW-1:0]  burst_cnt;
    logic [CW-1:0]  burst_cnt_nxt;
    logic           any_req;
    logic           keep_owner;

    logic           w_we;
    logic [31:0]    w_addr;
    logic [31:0]    w_wdata;
    logic [2:0]     w_func3;
    logic [32:0]    size;
    logic [32:0]    end_addr;
    logic           bad_func3;
    logic           misaligned;
    logic           out_of_range;
    logic           illegal;
    logic           legal_load;

    // burst_cnt==0 only occurs after reset: there is no burst to continue, so a tie
    // goes to the side opposite last_owner, which makes the CPU win the first tie.
    always_comb begin
        any_req     = cpu.req | i2c.req;
        other_owner = (last_owner == OWN_CPU) ? OWN_I2C : OWN_CPU;
        keep_owner  = (burst_cnt != '0) && (burst_cnt < CW'(MAX_BURST));
        winner      = OWN_CPU;
        if (cpu.req && i2c.req) begin
            winner = keep_owner ? last_owner : other_owner;
        end else if (i2c.req) begin
            winner = OWN_I2C;
        end

        if (winner != last_owner) begin
            burst_cnt_nxt = CW'(1);
        end else if (burst_cnt < CW'(MAX_BURST)) begin
            burst_cnt_nxt = burst_cnt + 1'b1;
        end else begin
            burst_cnt_nxt = burst_cnt;
        end
    end

    always_comb begin
        if (winner == OWN_I2C) begin
            w_we    = i2c.we;
            w_addr  = i2c.addr;
            w_wdata = i2c.wdata;
            w_func3 = i2c.func3;
        end else begin
            w_we    = cpu.we;
            w_addr  = cpu.addr;
            w_wdata = cpu.wdata;
            w_func3 = cpu.func3;
        end

        case (w_func3[1:0])
            2'b00:   size = 33'd1;
            2'b01:   size = 33'd2;
            default: size = 33'd4;
        endcase

        bad_func3    = w_we ? (w_func3 > 3'd2) : !(w_func3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        misaligned   = ((w_func3[1:0] == 2'b01) && w_addr[0]) ||
                       ((w_func3[1:0] == 2'b10) && (w_addr[1:0] != 2'b00));
        // 33-bit sum so an address near 2^32 cannot wrap back into range
        end_addr     = {1'b0, w_addr} + size;
        out_of_range = end_addr > 33'(MEM_BYTES);
        illegal      = bad_func3 | misaligned | out_of_range;
        legal_load   = !w_we && !illegal;

        cpu.gnt   = any_req && (winner == OWN_CPU);
        i2c.gnt   = any_req && (winner == OWN_I2C);

        mem_we    = any_req && w_we && !illegal;
        mem_a     = any_req ? w_addr  : 32'h0;
        mem_wd    = any_req ? w_wdata : 32'h0;
        mem_func3 = any_req ? w_func3 : 3'b010;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner <= OWN_I2C;
            burst_cnt  <= '0;
            cpu.rvalid <= 1'b0;
            cpu.err    <= 1'b0;
            cpu.rdata  <= 32'h0;
            i2c.rvalid <= 1'b0;
            i2c.err    <= 1'b0;
            i2c.rdata  <= 32'h0;
        end else begin
            cpu.rvalid <= cpu.gnt;
            cpu.err    <= cpu.gnt && illegal;
            cpu.rdata  <= (cpu.gnt && legal_load) ? mem_rd : 32'h0;
            i2c.rvalid <= i2c.gnt;
            i2c.err    <= i2c.gnt && illegal;
            i2c.rdata  <= (i2c.gnt && legal_load) ? mem_rd : 32'h0;
            if (any_req) begin
                last_owner <= winner;
                burst_cnt  <= burst_cnt_nxt;
            end
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a byte-array memory (sync write, comb read).
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [2:0]  mem_func3;
    logic [31:0] mem_rd;
    logic [7:0]  mem [0:1023];
    logic [9:0]  ra;
    logic [7:0]  b0, b1, b2, b3;

    int n_chk  = 0;
    int n_pass = 0;

    dmem_port_arbiter_if cpu_if ();
    dmem_port_arbiter_if i2c_if ();

    dmem_port_arbiter #(
        .MEM_BYTES (1024),
        .MAX_BURST (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu       (cpu_if),
        .i2c       (i2c_if),
        .mem_we    (mem_we),
        .mem_a     (mem_a),
        .mem_wd    (mem_wd),
        .mem_func3 (mem_func3),
        .mem_rd    (mem_rd)
    );

    always #5 clk = ~clk;

    always_comb begin
        ra = mem_a[9:0];
        b0 = mem[ra];
        b1 = mem[ra + 10'd1];
        b2 = mem[ra + 10'd2];
        b3 = mem[ra + 10'd3];
        case (mem_func3)
            3'b000:  mem_rd = {{24{b0[7]}}, b0};
            3'b001:  mem_rd = {{16{b1[7]}}, b1, b0};
            3'b100:  mem_rd = {24'h0, b0};
            3'b101:  mem_rd = {16'h0, b1, b0};
            default: mem_rd = {b3, b2, b1, b0};
        endcase
    end

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_a[9:0]] <= mem_wd[7:0];
            if (mem_func3[1:0] != 2'b00) mem[mem_a[9:0] + 10'd1] <= mem_wd[15:8];
            if (mem_func3[1:0] == 2'b10) begin
                mem[mem_a[9:0] + 10'd2] <= mem_wd[23:16];
                mem[mem_a[9:0] + 10'd3] <= mem_wd[31:24];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic drive(input int p, input logic req, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [2:0] f3);
        if (p == 0) begin
            cpu_if.req = req; cpu_if.we = we; cpu_if.addr = a; cpu_if.wdata = wd; cpu_if.func3 = f3;
        end else begin
            i2c_if.req = req; i2c_if.we = we; i2c_if.addr = a; i2c_if.wdata = wd; i2c_if.func3 = f3;
        end
    endtask

    // Single-requester access: comb grant/mem_we in the request cycle, response one cycle later.
    task automatic access(input int p, input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] f3, input logic exp_err, input logic [31:0] exp_rd,
                          input string tag);
        @(negedge clk);
        drive(p, 1'b1, we, a, wd, f3);
        #1;
        check({tag, " gnt"},       (p == 0) ? cpu_if.gnt : i2c_if.gnt, 32'd1);
        check({tag, " other_gnt"}, (p == 0) ? i2c_if.gnt : cpu_if.gnt, 32'd0);
        check({tag, " mem_we"},    mem_we, {31'd0, we & ~exp_err});
        @(posedge clk);
        #1;
        drive(p, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
        check({tag, " rvalid"},       (p == 0) ? cpu_if.rvalid : i2c_if.rvalid, 32'd1);
        check({tag, " err"},          (p == 0) ? cpu_if.err    : i2c_if.err,    {31'd0, exp_err});
        check({tag, " rdata"},        (p == 0) ? cpu_if.rdata  : i2c_if.rdata,  exp_rd);
        check({tag, " other_rvalid"}, (p == 0) ? i2c_if.rvalid : cpu_if.rvalid, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
        #2;
        check("rst cpu_rvalid", cpu_if.rvalid, 32'd0);
        check("rst cpu_err",    cpu_if.err,    32'd0);
        check("rst cpu_rdata",  cpu_if.rdata,  32'd0);
        check("rst i2c_rvalid", i2c_if.rvalid, 32'd0);
        check("rst mem_we",     mem_we,        32'd0);
        check("rst mem_a",      mem_a,         32'd0);
        check("rst mem_func3",  mem_func3,     32'd2);
        @(negedge clk);
        rst_n = 1'b1;

        access(0, 1'b1, 32'h100, 32'hDEADBEEF, 3'b010, 1'b0, 32'h0,        "sw100");
        access(0, 1'b0, 32'h100, 32'h0,        3'b010, 1'b0, 32'hDEADBEEF, "lw100");
        @(posedge clk);
        #1;
        check("rvalid one pulse", cpu_if.rvalid, 32'd0);

        access(0, 1'b1, 32'h103, 32'h80, 3'b000, 1'b0, 32'h0,        "sb103");
        access(0, 1'b0, 32'h103, 32'h0,  3'b000, 1'b0, 32'hFFFFFF80, "lb103");
        access(0, 1'b0, 32'h103, 32'h0,  3'b100, 1'b0, 32'h00000080, "lbu103");

        access(0, 1'b0, 32'h102, 32'h0,    3'b010, 1'b1, 32'h0,        "lw102 misal");
        access(0, 1'b1, 32'h101, 32'hFFFF, 3'b001, 1'b1, 32'h0,        "sh101 misal");
        access(0, 1'b0, 32'h100, 32'h0,    3'b010, 1'b0, 32'h80ADBEEF, "lw100 after");

        access(0, 1'b1, 32'h3FC,      32'h12345678, 3'b010, 1'b0, 32'h0,        "sw3fc");
        access(0, 1'b0, 32'h3FC,      32'h0,        3'b010, 1'b0, 32'h12345678, "lw3fc");
        access(0, 1'b1, 32'h3FE,      32'h1,        3'b010, 1'b1, 32'h0,        "sw3fe");
        access(0, 1'b0, 32'hFFFFFFFC, 32'h0,        3'b010, 1'b1, 32'h0,        "lw wrap");
        access(0, 1'b1, 32'h200,      32'h5,        3'b100, 1'b1, 32'h0,        "st f3 100");
        access(0, 1'b0, 32'h200,      32'h0,        3'b011, 1'b1, 32'h0,        "ld f3 011");
        access(0, 1'b0, 32'h3FC,      32'h0,        3'b010, 1'b0, 32'h12345678, "lw3fc again");

        access(1, 1'b1, 32'h200, 32'hCAFEF00D, 3'b010, 1'b0, 32'h0,        "i2c sw200");
        access(1, 1'b0, 32'h202, 32'h0,        3'b101, 1'b0, 32'h0000CAFE, "i2c lhu202");
        access(0, 1'b0, 32'h200, 32'h0,        3'b001, 1'b0, 32'hFFFFF00D, "cpu lh200");

        // contention: after reset CPU x4, I2C x4, CPU x4
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1'b1, 1'b0, 32'h100, 32'h0, 3'b010);
        drive(1, 1'b1, 1'b0, 32'h200, 32'h0, 3'b010);
        for (int i = 0; i < 12; i++) begin
            #1;
            check($sformatf("burst%0d cpu_gnt", i), cpu_if.gnt, {31'd0, ((i / 4) % 2) == 0});
            check($sformatf("burst%0d i2c_gnt", i), i2c_if.gnt, {31'd0, ((i / 4) % 2) == 1});
            @(negedge clk);
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);

        // async reset in the middle of a burst
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1'b1, 1'b0, 32'h100, 32'h0, 3'b010);
        drive(1, 1'b1, 1'b0, 32'h200, 32'h0, 3'b010);
        repeat (4) @(posedge clk);
        #1;
        check("pre-rst i2c_gnt",    i2c_if.gnt,    32'd1);
        check("pre-rst cpu_rvalid", cpu_if.rvalid, 32'd1);
        check("pre-rst cpu_rdata",  cpu_if.rdata,  32'h80ADBEEF);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst cpu_rvalid", cpu_if.rvalid, 32'd0);
        check("async rst cpu_rdata",  cpu_if.rdata,  32'd0);
        check("async rst i2c_rvalid", i2c_if.rvalid, 32'd0);
        check("async rst cpu_gnt",    cpu_if.gnt,    32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post-rst cpu_gnt", cpu_if.gnt, 32'd1);
        check("post-rst i2c_gnt", i2c_if.gnt, 32'd0);
        @(posedge clk);
        #1;
        check("post-rst cpu_rvalid", cpu_if.rvalid, 32'd1);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
